// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: sequencing controller for the 5-stage MIPS pipeline.
// Detects load-use hazards, squashes wrong-path fetches on taken branches and
// sequences the multi-cycle multiply/divide unit (MDU).
// Optional build macro: HAZARD_STATS_EN adds saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  id_mdu_op,
    input  logic                  id_mdu_div,
    input  logic                  id_reads_hilo,
    input  logic                  ex_branch_taken,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic                  mdu_start,
    output logic                  mdu_busy,
`ifdef HAZARD_STATS_EN
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt,
`endif
    output logic                  mdu_done
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    mdu_state_t       state;
    logic [CNT_W-1:0] count;
    logic             load_use;
    logic             mdu_hazard;
    logic             last_busy;

    // Hazard detection and stall/flush/launch priority
    always_comb begin
        load_use = ex_mem_read && (ex_rt != '0) &&
                   ((id_uses_rs && (id_rs == ex_rt)) ||
                    (id_uses_rt && (id_rt == ex_rt)));
        // The final BUSY cycle (count==0) lets a waiting op or mfhi/mflo through
        mdu_hazard = (id_mdu_op || id_reads_hilo) && (state == BUSY) && (count != '0);
        mdu_start  = id_mdu_op && !ex_branch_taken && !load_use && !mdu_hazard;

        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (ex_branch_taken) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (load_use || mdu_hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // MDU status decoded straight from the FSM registers
    always_comb begin
        mdu_busy  = (state == BUSY);
        last_busy = (state == BUSY) && (count == '0);
        mdu_done  = last_busy;
    end

    // MDU sequencing FSM: launch, count down, optional back-to-back reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdu_start) begin
                        state <= BUSY;
                        count <= id_mdu_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        if (mdu_start) begin
                            count <= id_mdu_div ? DIV_LOAD : MUL_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating counters of stalled cycles and flushed fetches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (if_id_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with fixed
// expectations plus randomized traffic against a remaining-cycles MDU model.
module tb_pipeline_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rs, id_uses_rt, ex_mem_read;
    logic       id_mdu_op, id_mdu_div, id_reads_hilo, ex_branch_taken;
    logic       pc_write, if_id_write, id_ex_bubble, if_id_flush;
    logic       mdu_start, mdu_busy, mdu_done;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int passes = 0;

    // Reference model state: cycles of MDU occupancy still ahead, including now
    int rem = 0;
    int stall_q = 0;
    int flush_q = 0;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(5),
        .MUL_CYCLES(MUL_LAT),
        .DIV_CYCLES(DIV_LAT),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt),
        .id_mdu_op(id_mdu_op),
        .id_mdu_div(id_mdu_div),
        .id_reads_hilo(id_reads_hilo),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush),
        .mdu_start(mdu_start),
        .mdu_busy(mdu_busy),
`ifdef HAZARD_STATS_EN
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt),
`endif
        .mdu_done(mdu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_start, mdu_busy, mdu_done}
    function automatic logic [6:0] observed();
        return {pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_start, mdu_busy, mdu_done};
    endfunction

    function automatic logic [6:0] model_outs();
        logic lu, mh, st;
        logic [3:0] ctl;
        lu = ex_mem_read && (ex_rt != 0) &&
             ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        mh = (id_mdu_op || id_reads_hilo) && (rem > 1);
        st = id_mdu_op && !ex_branch_taken && !lu && !mh;
        if (ex_branch_taken) ctl = 4'b1111;
        else if (lu || mh)   ctl = 4'b0010;
        else                 ctl = 4'b1100;
        return {ctl, st, rem > 0, rem == 1};
    endfunction

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_rt = 0;
        id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
        id_mdu_op = 0; id_mdu_div = 0; id_reads_hilo = 0; ex_branch_taken = 0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic step();
        logic [6:0] e;
        e = model_outs();
        @(posedge clk);
        if (!rst_n) begin
            rem = 0; stall_q = 0; flush_q = 0;
        end else begin
            if (e[2]) rem = id_mdu_div ? DIV_LAT : MUL_LAT;
            else if (rem > 0) rem = rem - 1;
            if (!e[6] && stall_q < 65535) stall_q++;
            if (e[3] && flush_q < 65535) flush_q++;
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        rem = 0; stall_q = 0; flush_q = 0;
        step();
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 rst_n = 0;
        rem = 0; stall_q = 0; flush_q = 0;
        #1;
        checks++;
        if (observed() !== 7'b1100000) $display("FAIL reset_outputs got=%b exp=%b", observed(), 7'b1100000);
        else passes++;
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) $display("FAIL reset_stats got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        else passes++;
`endif
        step();
        rst_n = 1;
        step();
        checks++;
        if (observed() !== 7'b1100000) $display("FAIL reset_release got=%b exp=%b", observed(), 7'b1100000);
        else passes++;
    endtask

    task automatic test_load_use();
        clear_inputs();
        ex_mem_read = 1; ex_rt = 8; id_rs = 8; id_uses_rs = 1; id_rt = 3; id_uses_rt = 1;
        #1;
        checks++;
        if (observed() !== 7'b0010000) $display("FAIL load_use_stall got=%b exp=%b", observed(), 7'b0010000);
        else passes++;
        step();
        ex_mem_read = 0; ex_rt = 0;
        #1;
        checks++;
        if (observed() !== 7'b1100000) $display("FAIL load_use_resume got=%b exp=%b", observed(), 7'b1100000);
        else passes++;
        // rt-side match only counts when rt is actually read
        ex_mem_read = 1; ex_rt = 9; id_rs = 2; id_rt = 9; id_uses_rt = 0;
        #1;
        checks++;
        if (observed() !== 7'b1100000) $display("FAIL load_rt_unused got=%b exp=%b", observed(), 7'b1100000);
        else passes++;
        id_uses_rt = 1;
        #1;
        checks++;
        if (observed() !== 7'b0010000) $display("FAIL load_rt_used got=%b exp=%b", observed(), 7'b0010000);
        else passes++;
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_load_zero();
        clear_inputs();
        ex_mem_read = 1; ex_rt = 0; id_rs = 0; id_uses_rs = 1; id_rt = 0; id_uses_rt = 1;
        #1;
        checks++;
        if (observed() !== 7'b1100000) $display("FAIL load_zero got=%b exp=%b", observed(), 7'b1100000);
        else passes++;
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_mult_mfhi();
        logic [6:0] exp_seq [6];
        exp_seq = '{7'b1100100, 7'b1100010, 7'b0010010, 7'b0010010, 7'b1100011, 7'b1100000};
        clear_inputs();
        for (int c = 0; c < 6; c++) begin
            id_mdu_op = (c == 0);
            id_reads_hilo = (c >= 2 && c <= 4);
            #1;
            checks++;
            if (observed() !== exp_seq[c]) $display("FAIL mult_mfhi_c%0d got=%b exp=%b", c, observed(), exp_seq[c]);
            else passes++;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        int busy_cycles = 0;
        logic [6:0] e;
        clear_inputs();
        id_mdu_op = 1; id_mdu_div = 1;
        for (int c = 0; c <= 66; c++) begin
            if (c == 33) id_mdu_op = 0;
            if (c == 0 || c == 32)      e = (c == 0) ? 7'b1100100 : 7'b1100111;
            else if (c < 32)            e = 7'b0010010;
            else if (c < 64)            e = 7'b1100010;
            else if (c == 64)           e = 7'b1100011;
            else                        e = 7'b1100000;
            #1;
            if (mdu_busy) busy_cycles++;
            checks++;
            if (observed() !== e) $display("FAIL b2b_div_c%0d got=%b exp=%b", c, observed(), e);
            else passes++;
            step();
        end
        checks++;
        if (busy_cycles != 64) $display("FAIL b2b_busy_total got=%0d exp=64", busy_cycles);
        else passes++;
        clear_inputs();
    endtask

    task automatic test_branch_priority();
        clear_inputs();
        ex_branch_taken = 1; ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 1; id_mdu_op = 1;
        #1;
        checks++;
        if (observed() !== 7'b1111000) $display("FAIL branch_priority got=%b exp=%b", observed(), 7'b1111000);
        else passes++;
        step();
        // A branch does not abort an MDU op already in flight
        clear_inputs();
        id_mdu_op = 1;
        step();
        clear_inputs();
        ex_branch_taken = 1;
        #1;
        checks++;
        if (observed() !== 7'b1111010) $display("FAIL branch_keeps_mdu got=%b exp=%b", observed(), 7'b1111010);
        else passes++;
        step();
        clear_inputs();
        for (int c = 0; c < 4; c++) step();
    endtask

    task automatic test_reset_mid_div();
        int dones = 0;
        clear_inputs();
        id_mdu_op = 1; id_mdu_div = 1;
        step();
        clear_inputs();
        // 21 more edges bring the counter from 31 down to 10
        for (int c = 0; c < 21; c++) step();
        #1;
        checks++;
        if (mdu_busy !== 1'b1 || mdu_done !== 1'b0) $display("FAIL mid_div_busy got=%b%b exp=10", mdu_busy, mdu_done);
        else passes++;
        rst_n = 0;
        rem = 0; stall_q = 0; flush_q = 0;
        #1;
        checks++;
        if (observed() !== 7'b1100000) $display("FAIL mid_div_reset got=%b exp=%b", observed(), 7'b1100000);
        else passes++;
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) $display("FAIL mid_div_stats got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        else passes++;
`endif
        step();
        rst_n = 1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (mdu_done || mdu_busy) dones++;
        end
        checks++;
        if (dones != 0) $display("FAIL mid_div_no_done got=%0d exp=0", dones);
        else passes++;
    endtask

    task automatic test_random();
        logic [6:0] e;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom_range(0, 1));
            id_uses_rt = 1'($urandom_range(0, 1));
            ex_mem_read = ($urandom_range(0, 3) == 0);
            id_mdu_op = ($urandom_range(0, 3) == 0);
            id_mdu_div = ($urandom_range(0, 4) == 0);
            id_reads_hilo = ($urandom_range(0, 5) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            #1;
            e = model_outs();
            checks++;
            if (observed() !== e) $display("FAIL random_c%0d got=%b exp=%b", c, observed(), e);
            else passes++;
`ifdef HAZARD_STATS_EN
            checks++;
            if (stall_cnt !== 16'(stall_q) || flush_cnt !== 16'(flush_q))
                $display("FAIL random_stats_c%0d got=%0d/%0d exp=%0d/%0d", c, stall_cnt, flush_cnt, stall_q, flush_q);
            else passes++;
`endif
            step();
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_load_zero();
        test_mult_mfhi();
        test_back_to_back();
        test_branch_priority();
        test_reset_mid_div();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
